// File: rtl/add_sub_pkg.sv
// Shared constants for the registered adder/subtractor.
//   WIDTH          default operand/result width
//   OP_ADD/OP_SUB  encoding of the D (operation) input
//   MODE_*         encoding of the Si (interpretation) input
package add_sub_pkg;

    localparam int WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/add_sub_cla_adder.sv
// Combinational carry-lookahead adder. Bits are handled in 4-bit lookahead
// groups whose group generate/propagate terms feed a group-carry chain.
// Ports:
//   a, b      WIDTH-bit addends
//   cin       carry into bit 0
//   sum       a + b + cin modulo 2^WIDTH
//   c_msb_in  carry into bit WIDTH-1
//   c_out     carry out of bit WIDTH-1
module cla_adder
    import add_sub_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         c_msb_in,
    output logic         c_out
);

    // Widths that are not a multiple of 4 are zero-padded; padded bits have
    // p=g=0 so the carry at position W is still exact.
    localparam int NG = (W + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] a_pad;
    logic [PW-1:0] b_pad;
    logic [PW-1:0] p;
    logic [PW-1:0] g;
    logic [PW:0]   carry;

    assign a_pad = PW'(a);
    assign b_pad = PW'(b);
    assign p     = a_pad ^ b_pad;
    assign g     = a_pad & b_pad;

    always_comb begin
        logic [3:0] gp;
        logic [3:0] gg;
        logic       grp_p;
        logic       grp_g;
        logic       ci;
        carry    = '0;
        carry[0] = cin;
        for (int gi = 0; gi < NG; gi++) begin
            gp = p[gi*4 +: 4];
            gg = g[gi*4 +: 4];
            ci = carry[gi*4];
            carry[gi*4+1] = gg[0] | (gp[0] & ci);
            carry[gi*4+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
            carry[gi*4+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                          | (gp[2] & gp[1] & gp[0] & ci);
            grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                  | (gp[3] & gp[2] & gp[1] & gg[0]);
            grp_p = &gp;
            carry[gi*4+4] = grp_g | (grp_p & ci);
        end
    end

    assign sum      = p[W-1:0] ^ carry[W-1:0];
    assign c_msb_in = carry[W-1];
    assign c_out    = carry[W];

endmodule

// File: rtl/add_sub.sv
// Registered WIDTH-bit adder/subtractor with carry, true-sign and overflow
// flags. Results appear one clock after in_valid; no backpressure.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   in_valid         operands/controls presented this cycle
//   Si               0 = unsigned, 1 = two's-complement operands
//   D                0 = add (A+B+Cin), 1 = subtract (A-B, Cin ignored)
//   Cin              carry-in for add
//   A, B             operands
//   out_valid        registered outputs hold a new result this cycle
//   S, Cout, So, V   result, carry out, exact-result sign, overflow
module add_sub
    import add_sub_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         Si,
    input  logic         D,
    input  logic         Cin,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    output logic [W-1:0] S,
    output logic         Cout,
    output logic         So,
    output logic         V
);

    logic [W-1:0] bx;
    logic         c0;
    logic [W-1:0] s_d;
    logic         c_msb;
    logic         cout_d;
    logic         v_d;
    logic         so_d;

    logic         out_valid_q;
    logic [W-1:0] s_q;
    logic         cout_q;
    logic         so_q;
    logic         v_q;

    // Subtraction is A + ~B + 1.
    assign bx = B ^ {W{D}};
    assign c0 = (D == OP_SUB) ? 1'b1 : Cin;

    cla_adder #(.W(W)) u_cla (
        .a        (A),
        .b        (bx),
        .cin      (c0),
        .sum      (s_d),
        .c_msb_in (c_msb),
        .c_out    (cout_d)
    );

    always_comb begin
        v_d  = 1'b0;
        so_d = 1'b0;
        if (Si == MODE_SIGNED) begin
            v_d  = c_msb ^ cout_d;
            // On overflow the wrapped MSB is the inverse of the true sign.
            so_d = s_d[W-1] ^ v_d;
        end else if (D == OP_ADD) begin
            v_d  = cout_d;
            so_d = 1'b0;
        end else begin
            // Unsigned subtract: no carry out means a borrow, i.e. A < B.
            v_d  = ~cout_d;
            so_d = ~cout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            so_q        <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
                so_q   <= so_d;
                v_q    <= v_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign So        = so_q;
    assign V         = v_q;

endmodule

// File: tb/tb_add_sub.sv
module tb_add_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        Si;
    logic        D;
    logic        Cin;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic [31:0] S;
    logic        Cout;
    logic        So;
    logic        V;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Si        (Si),
        .D         (D),
        .Cin       (Cin),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .S         (S),
        .Cout      (Cout),
        .So        (So),
        .V         (V)
    );

    typedef struct {
        logic        si;
        logic        d;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        cout;
        logic        so;
        logic        v;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    // Compare {out_valid, S, Cout, So, V} against expected values.
    task automatic check(input string name, input logic ov, input logic [31:0] s,
                         input logic c, input logic so, input logic v);
        checks++;
        if ({out_valid, S, Cout, So, V} !== {ov, s, c, so, v}) begin
            failures++;
            $display("FAIL %s: got ov=%0b S=%08h Cout=%0b So=%0b V=%0b, want ov=%0b S=%08h Cout=%0b So=%0b V=%0b",
                     name, out_valid, S, Cout, So, V, ov, s, c, so, v);
        end
    endtask

    task automatic drive(input logic iv, input logic si, input logic d, input logic cin,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = iv;
        Si       = si;
        D        = d;
        Cin      = cin;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                si    d    cin  a             b             s             cout  so    v
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h00000005, 32'h00000003, 32'h00000009, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'd5001,     32'd3000,     32'd2001,     1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'd15,       32'hFFFFFFF1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h00001388, 32'hFFFFF830, 32'h00000BB8, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFF6, 32'h80000000, 32'h7FFFFFF6, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h00000004, 32'h7FFFFFFF, 32'h80000003, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hFFFFD8F0, 32'hFFFFD8F0, 32'hFFFFB1E1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h7FFFFFFD, 32'hFFFFFFFD, 32'h80000000, 1'b0, 1'b0, 1'b1};
        // Cin must be ignored on subtraction
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'd5001,     32'd3000,     32'd2001,     1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h7FFFFFFD, 32'hFFFFFFFD, 32'h80000000, 1'b0, 1'b0, 1'b1};
        // signed boundaries
        vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h80000000, 32'h00000000, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0};
        // A - A in both modes
        vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        // full carry propagation through every group
        vecs[21] = '{1'b0, 1'b0, 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].si, vecs[i].d, vecs[i].cin, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), 1'b1, vecs[i].s, vecs[i].cout, vecs[i].so, vecs[i].v);
        end

        // Valid handling: outputs hold when in_valid drops.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd3);
        check("valid_on", 1'b1, 32'h00000008, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        check("valid_off_hold", 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd15);
        check("valid_off_hold2", 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream overrides in_valid.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("pre_reset", 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'd15);
        check("mid_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h00000004, 32'h7FFFFFFF);
        check("post_reset", 1'b1, 32'h80000003, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("post_reset_idle", 1'b0, 32'h80000003, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
